xbar_rr: RTL

XBAR_RR -- requirements
Module: xbar_rr

---
 rtl/xbar_rr_pkg.sv | 16 +
 rtl/xbar_rr_if.sv | 39 +++
 rtl/xbar_rr_fifo.sv | 55 +++++
 rtl/xbar_rr.sv | 89 ++++++++
 4 files changed

// File: rtl/xbar_rr_pkg.sv
// Shared definitions for the round-robin crossbar: packet layout and default sizing.
package xbar_rr_pkg;

    localparam int unsigned DEF_NUM_SRC    = 4;
    localparam int unsigned DEF_NUM_DST    = 4;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned INDEX_W        = 8;
    localparam int unsigned DATA_W         = 16;

    typedef struct packed {
        logic               valid;
        logic [INDEX_W-1:0] index;
        logic [DATA_W-1:0]  data;
    } data_packet_t;

endpackage

// File: rtl/xbar_rr_if.sv
// Source/destination bundle of the crossbar; master drives sources and consumers, slave is the crossbar.
interface xbar_rr_if
    import xbar_rr_pkg::*;
#(
    parameter int unsigned NUM_SRC    = DEF_NUM_SRC,
    parameter int unsigned NUM_DST    = DEF_NUM_DST,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
);

    data_packet_t [NUM_SRC-1:0]            in_packet;
    logic         [NUM_SRC-1:0]            in_ready;
    data_packet_t [NUM_DST-1:0]            out_packet;
    logic         [NUM_DST-1:0]            out_valid;
    logic         [NUM_DST-1:0]            out_ready;
    logic         [NUM_DST-1:0][CNT_W-1:0] fifo_count;
    logic                                  busy;

    modport master (
        output in_packet,
        output out_ready,
        input  in_ready,
        input  out_packet,
        input  out_valid,
        input  fifo_count,
        input  busy
    );

    modport slave (
        input  in_packet,
        input  out_ready,
        output in_ready,
        output out_packet,
        output out_valid,
        output fifo_count,
        output busy
    );

endinterface

// File: rtl/xbar_rr_fifo.sv
// Single-push/single-pop destination FIFO; full/empty come from the occupancy count.
module xbar_rr_fifo
    import xbar_rr_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH),
    localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  data_packet_t     push_data,
    input  logic             pop,
    output data_packet_t     head,
    output logic             not_empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    data_packet_t     mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; stale entries are masked by the count.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

    assign head      = mem[rd_ptr_q];
    assign not_empty = (count_q != '0);
    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign count     = count_q;

endmodule

// File: rtl/xbar_rr.sv
// Source-to-destination crossbar with a round-robin arbiter and a FIFO per destination.
module xbar_rr
    import xbar_rr_pkg::*;
#(
    parameter int unsigned NUM_SRC    = DEF_NUM_SRC,
    parameter int unsigned NUM_DST    = DEF_NUM_DST,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input logic      clock,
    input logic      reset,
    xbar_rr_if.slave bus
);

    localparam int unsigned SRC_W = $clog2(NUM_SRC);
    localparam int unsigned DST_W = $clog2(NUM_DST);

    logic [NUM_SRC-1:0] grant [NUM_DST];
    logic [NUM_DST-1:0] space;
    logic [NUM_SRC-1:0] src_valid;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [DST_W-1:0] dst;
        assign src_valid[i]    = bus.in_packet[i].valid;
        assign dst             = bus.in_packet[i].index[DST_W-1:0];
        assign bus.in_ready[i] = grant[dst][i] & space[dst];
    end

    for (genvar d = 0; d < NUM_DST; d++) begin : g_dst
        logic [NUM_SRC-1:0] req;
        logic [SRC_W-1:0]   rr_ptr_q, gnt_idx;
        logic               gnt_any, pop, push, full;
        data_packet_t       push_data;

        for (genvar i = 0; i < NUM_SRC; i++) begin : g_req
            assign req[i] = bus.in_packet[i].valid &&
                            (bus.in_packet[i].index[DST_W-1:0] == DST_W'(d));
        end

        // First requester at or after rr_ptr_q, wrapping modulo NUM_SRC.
        always_comb begin
            int unsigned idx;
            idx     = 0;
            gnt_any = 1'b0;
            gnt_idx = '0;
            for (int unsigned k = 0; k < NUM_SRC; k++) begin
                idx = (int'(rr_ptr_q) + k) % NUM_SRC;
                if (!gnt_any && req[SRC_W'(idx)]) begin
                    gnt_any = 1'b1;
                    gnt_idx = SRC_W'(idx);
                end
            end
        end

        assign grant[d] = gnt_any ? (NUM_SRC'(1) << gnt_idx) : '0;
        assign pop      = bus.out_valid[d] & bus.out_ready[d];
        assign space[d] = ~full | pop;
        assign push     = gnt_any & space[d];

        always_comb begin
            push_data       = bus.in_packet[gnt_idx];
            push_data.valid = 1'b1;
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                rr_ptr_q <= '0;
            end else if (push) begin
                rr_ptr_q <= (gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end

        xbar_rr_fifo #(
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clock     (clock),
            .reset     (reset),
            .push      (push),
            .push_data (push_data),
            .pop       (pop),
            .head      (bus.out_packet[d]),
            .not_empty (bus.out_valid[d]),
            .full      (full),
            .count     (bus.fifo_count[d])
        );
    end

    assign bus.busy = (|bus.out_valid) | (|src_valid);

endmodule
